ucsbece154a_controller: RTL and testbench
=========================================

UCSBECE154A_CONTROLLER -- requirements
Module: ucsbece154a_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Port list follows, clock and reset first.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  async active-low reset; forces FETCH.
REQ-004 op_i  input  6  instruction opcode (IR[31:26]).
REQ-005 funct_i  input  6  R-type funct field (IR[5:0]).
REQ-006 zero_i  input  1  ALU zero flag.
REQ-007 pc_en_o  output  1  PC register enable.
REQ-008 ir_write_o, mem_write_o, reg_write_o  output  1 each  write enables.
REQ-009 iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o  output  1 each  datapath mux selects.
REQ-010 alu_src_b_o  output  2  ALU B select: 00=reg B, 01=const 4, 10=SignImm, 11=SignImm<<2.
REQ-011 pc_src_o  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-012 alu_control_o  output  3  ALU function code.
REQ-013 state_o  output  4  current FSM state, for debug.

Function
REQ-014 ALU codes SHALL be and=000, or=001, add=010, lu=011, sub=110, slt=111, matching the shared defines header.
REQ-015 Supported opcodes SHALL be R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010, lui=001111.
REQ-016 Supported functs SHALL be add=100000, sub=100010, and=100100, or=100101, slt=101010.
REQ-017 The Moore FSM state encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, IMMWB=10, JUMP=11, LUIEX=12; codes 13-15 go to FETCH on the next edge.
REQ-018 FETCH SHALL drive iord=0, srcA=0, srcB=01, alu=add, pc_src=00, ir_write=1, pc_write=1; next state DECODE.
REQ-019 DECODE SHALL drive srcA=0, srcB=11, alu=add to compute the branch target.
REQ-020 DECODE next state: lw/sw→MEMADR, R→EXECUTE, beq→BRANCH, addi→ADDIEX, j→JUMP, lui→LUIEX.
REQ-021 DECODE SHALL go to FETCH for an unsupported opcode, or for R-type with an unsupported funct; no write occurs.
REQ-022 MEMADR SHALL drive srcA=1, srcB=10, alu=add; next state MEMRD if lw, MEMWR if sw.
REQ-023 MEMRD SHALL drive iord=1; next state MEMWB.
REQ-024 MEMWB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
REQ-025 MEMWR SHALL drive iord=1, mem_write=1; next state FETCH.
REQ-026 EXECUTE SHALL drive srcA=1, srcB=00, alu from funct_i; next state ALUWB.
REQ-027 ALUWB SHALL drive reg_dst=1, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-028 BRANCH SHALL drive srcA=1, srcB=00, alu=sub, pc_src=01, branch=1; next state FETCH.
REQ-029 ADDIEX SHALL drive srcA=1, srcB=10, alu=add; LUIEX SHALL drive srcA=1, srcB=10, alu=lu; both go to IMMWB.
REQ-030 IMMWB SHALL drive reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-031 JUMP SHALL drive pc_src=10, pc_write=1; next state FETCH.
REQ-032 Every signal not listed for a state SHALL be 0 (alu=add, srcB=00).
REQ-033 pc_en_o SHALL equal pc_write | (branch & zero_i), combinationally in the same cycle.
REQ-034 Instruction cycle counts: lw=5, sw=4, R=4, addi=4, lui=4, beq=3, j=3, unsupported=2.
REQ-035 Only alu_control_o (in EXECUTE) and pc_en_o SHALL depend on inputs other than state.

Reset
REQ-036 Asserting reset_n low SHALL immediately set state=FETCH, regardless of clock or current state.
REQ-037 While reset_n is low, pc_en_o, ir_write_o, mem_write_o and reg_write_o SHALL be 0; all other outputs SHALL hold their FETCH values.
REQ-038 At the first rising edge after reset_n goes high, FETCH write enables SHALL be active.

Verification
REQ-039 Reset mid-MEMWR, with reset_n low between edges → state_o=0 at once and mem_write_o=0 at once; after release, FETCH then DECODE.
REQ-040 lw (op=100011) → states 0,1,2,3,4,0; reg_write_o=1 only in state 4, with mem_to_reg_o=1.
REQ-041 R-type sub (funct=100010) → alu_control_o=110 in EXECUTE, then reg_write_o=1, reg_dst_o=1; R-type funct=000000 → DECODE→FETCH, with no write.
REQ-042 beq with zero_i=1 → pc_en_o=1 in BRANCH; beq with zero_i=0 → pc_en_o=0; both return to FETCH.
REQ-043 lui → alu_control_o=011 and srcB=10 in LUIEX, then IMMWB with reg_write_o=1; j → pc_src_o=10 and pc_en_o=1 in JUMP.
REQ-044 Unsupported opcode 111111 → DECODE→FETCH; mem_write_o and reg_write_o never 1.

Source files
------------

// File: rtl/ucsbece154a_controller.sv
// Multicycle MIPS-subset main controller: Moore FSM plus ALU decoder.
// Write enables are forced low while reset_n is held low.
`timescale 1ns/1ps
module ucsbece154a_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    output logic       pc_en_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       iord_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] alu_control_o,
    output logic [3:0] state_o
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LU  = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11,
        LUIEX   = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // R-type funct decode; funct_ok gates DECODE so bad functs never reach EXECUTE.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct_i)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        iord_o        = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        pc_src_o      = 2'b00;
        alu_control_o = ALU_ADD;
        case (state_q)
            FETCH: begin
                alu_src_b_o = 2'b01;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                case (op_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = funct_ok ? EXECUTE : FETCH;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_LUI:       state_d = LUIEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                if (op_i == OP_LW) begin
                    state_d = MEMRD;
                end else if (op_i == OP_SW) begin
                    state_d = MEMWR;
                end
            end
            MEMRD: begin
                iord_o  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write    = 1'b1;
            end
            MEMWR: begin
                iord_o    = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = funct_alu;
                state_d       = ALUWB;
            end
            ALUWB: begin
                reg_dst_o = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = ALU_SUB;
                pc_src_o      = 2'b01;
                branch        = 1'b1;
            end
            ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = IMMWB;
            end
            LUIEX: begin
                alu_src_a_o   = 1'b1;
                alu_src_b_o   = 2'b10;
                alu_control_o = ALU_LU;
                state_d       = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src_o = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign pc_en_o     = reset_n & (pc_write | (branch & zero_i));
    assign ir_write_o  = reset_n & ir_write;
    assign mem_write_o = reset_n & mem_write;
    assign reg_write_o = reset_n & reg_write;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ucsbece154a_controller.sv
// Directed bench for the multicycle controller: per-cycle expected outputs are
// queued when an instruction is issued and compared on each falling edge.
`timescale 1ns/1ps
module tb_ucsbece154a_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       pc_en_o, ir_write_o, mem_write_o, reg_write_o;
    logic       iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
    logic [1:0] alu_src_b_o, pc_src_o;
    logic [2:0] alu_control_o;
    logic [3:0] state_o;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       iord;
        logic       rdst;
        logic       m2r;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic [2:0] alu;
    } outs_t;

    outs_t  exp_q[$];
    outs_t  obs;
    outs_t  e;
    int     errors = 0;
    int     checks = 0;

    ucsbece154a_controller dut (
        .clk(clk), .reset_n(reset_n), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
        .pc_en_o(pc_en_o), .ir_write_o(ir_write_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .iord_o(iord_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .pc_src_o(pc_src_o), .alu_control_o(alu_control_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Expected outputs per state, written straight from the state table.
    function automatic outs_t mk(input logic [3:0] st, input logic pc_en, input logic irw,
                                 input logic mw, input logic rw, input logic iord,
                                 input logic rdst, input logic m2r, input logic sa,
                                 input logic [1:0] sb, input logic [1:0] ps,
                                 input logic [2:0] alu);
        return '{st, pc_en, irw, mw, rw, iord, rdst, m2r, sa, sb, ps, alu};
    endfunction

    function automatic outs_t s_fetch();   return mk(0, 1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010); endfunction
    function automatic outs_t s_rst();     return mk(0, 0,0,0,0,0,0,0,0, 2'b01,2'b00,3'b010); endfunction
    function automatic outs_t s_decode();  return mk(1, 0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010); endfunction
    function automatic outs_t s_memadr();  return mk(2, 0,0,0,0,0,0,0,1, 2'b10,2'b00,3'b010); endfunction
    function automatic outs_t s_memrd();   return mk(3, 0,0,0,0,1,0,0,0, 2'b00,2'b00,3'b010); endfunction
    function automatic outs_t s_memwb();   return mk(4, 0,0,0,1,0,0,1,0, 2'b00,2'b00,3'b010); endfunction
    function automatic outs_t s_memwr();   return mk(5, 0,0,1,0,1,0,0,0, 2'b00,2'b00,3'b010); endfunction
    function automatic outs_t s_exec(input logic [2:0] a);
                                           return mk(6, 0,0,0,0,0,0,0,1, 2'b00,2'b00,a); endfunction
    function automatic outs_t s_aluwb();   return mk(7, 0,0,0,1,0,1,0,0, 2'b00,2'b00,3'b010); endfunction
    function automatic outs_t s_branch(input logic z);
                                           return mk(8, z,0,0,0,0,0,0,1, 2'b00,2'b01,3'b110); endfunction
    function automatic outs_t s_addiex();  return mk(9, 0,0,0,0,0,0,0,1, 2'b10,2'b00,3'b010); endfunction
    function automatic outs_t s_immwb();   return mk(10,0,0,0,1,0,0,0,0, 2'b00,2'b00,3'b010); endfunction
    function automatic outs_t s_jump();    return mk(11,1,0,0,0,0,0,0,0, 2'b00,2'b10,3'b010); endfunction
    function automatic outs_t s_luiex();   return mk(12,0,0,0,0,0,0,0,1, 2'b10,2'b00,3'b011); endfunction

    task automatic check(input string tag);
        obs = '{state_o, pc_en_o, ir_write_o, mem_write_o, reg_write_o, iord_o, reg_dst_o,
                mem_to_reg_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_control_o};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
            $display("check %-10s state=%0d observed=%h expected=%h", tag, state_o, obs, e);
        end
    endtask

    // Issue one instruction from FETCH: inputs are set, then one compare per cycle.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z);
        op_i    = op;
        funct_i = fn;
        zero_i  = z;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            check(tag);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        op_i    = 6'b0;
        funct_i = 6'b0;
        zero_i  = 1'b0;
        #7;
        exp_q.push_back(s_rst());
        check("reset");
        @(negedge clk);
        #1 reset_n = 1'b1;
        #1;
        exp_q.push_back(s_fetch());
        check("rel_fetch");
        exp_q.push_back(s_decode());
        @(negedge clk);
        check("rel_decode");
        exp_q.push_back(s_fetch());
        run("unsup_r", 6'b000000, 6'b000000, 1'b0); // DECODE saw R/funct 0 -> FETCH

        exp_q.push_back(s_decode());
        exp_q.push_back(s_memadr()); exp_q.push_back(s_memrd()); exp_q.push_back(s_memwb());
        exp_q.push_back(s_fetch());
        run("lw", 6'b100011, 6'b000000, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_exec(3'b110)); exp_q.push_back(s_aluwb()); exp_q.push_back(s_fetch());
        run("r_sub", 6'b000000, 6'b100010, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_exec(3'b010)); exp_q.push_back(s_aluwb()); exp_q.push_back(s_fetch());
        run("r_add", 6'b000000, 6'b100000, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_exec(3'b000)); exp_q.push_back(s_aluwb()); exp_q.push_back(s_fetch());
        run("r_and", 6'b000000, 6'b100100, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_exec(3'b001)); exp_q.push_back(s_aluwb()); exp_q.push_back(s_fetch());
        run("r_or", 6'b000000, 6'b100101, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_exec(3'b111)); exp_q.push_back(s_aluwb()); exp_q.push_back(s_fetch());
        run("r_slt", 6'b000000, 6'b101010, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_branch(1'b1)); exp_q.push_back(s_fetch());
        run("beq_z1", 6'b000100, 6'b000000, 1'b1);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_branch(1'b0)); exp_q.push_back(s_fetch());
        run("beq_z0", 6'b000100, 6'b000000, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_addiex()); exp_q.push_back(s_immwb()); exp_q.push_back(s_fetch());
        run("addi", 6'b001000, 6'b000000, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_luiex()); exp_q.push_back(s_immwb()); exp_q.push_back(s_fetch());
        run("lui", 6'b001111, 6'b000000, 1'b0);

        exp_q.push_back(s_decode());
        exp_q.push_back(s_jump()); exp_q.push_back(s_fetch());
        run("j", 6'b000010, 6'b000000, 1'b0);

        exp_q.push_back(s_decode()); exp_q.push_back(s_fetch());
        run("op_3f", 6'b111111, 6'b100000, 1'b0);

        // sw, with reset pulsed low between edges while in MEMWR
        exp_q.push_back(s_decode());
        exp_q.push_back(s_memadr()); exp_q.push_back(s_memwr());
        run("sw", 6'b101011, 6'b000000, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        exp_q.push_back(s_rst());
        check("rst_memwr");
        #1 reset_n = 1'b1;
        #1;
        exp_q.push_back(s_fetch());
        check("rst_fetch");
        exp_q.push_back(s_decode());
        exp_q.push_back(s_memadr()); exp_q.push_back(s_memwr()); exp_q.push_back(s_fetch());
        run("sw_again", 6'b101011, 6'b000000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
